alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational `alu` datapath between two requesters: the execute-stage sequencer (port 0) and the branch/compare unit (port 1). It arbitrates valid/ready requests round-robin and registers the winning operands onto the ALU inputs. It captures `Q`/`CMP` one cycle later and holds the result in a response register until the owning requester accepts it. It sits between the core control FSM and the `alu` instance; nothing else drives the ALU inputs.

## Interface
- `WIDTH`, default 32: operand and result width; must match the ALU.
- `OPW`, default 6: ALU opcode width (`S`).
- `CLK` in 1: rising-edge clock.
- `RST` in 1: synchronous, active-high reset.
- `REQ0_VALID`, `REQ1_VALID` in 1: request present.
- `REQ0_READY`, `REQ1_READY` out 1: request accepted on this edge when VALID is also high.
- `REQ0_S`, `REQ1_S` in OPW: ALU opcode.
- `REQ0_A`, `REQ0_B`, `REQ1_A`, `REQ1_B` in WIDTH: operands, signed.
- `RSP0_VALID`, `RSP1_VALID` out 1: response held for that requester.
- `RSP0_READY`, `RSP1_READY` in 1: requester consumes the response.
- `RSP_Q` out WIDTH: captured ALU result, shared by both response ports.
- `RSP_CMP` out 1: captured ALU compare flag.
- `ALU_S` out OPW, `ALU_A` out WIDTH, `ALU_B` out WIDTH: registered drive to the ALU.
- `ALU_Q` in WIDTH, `ALU_CMP` in 1: combinational ALU outputs.
- `BUSY` out 1: high whenever the state is not IDLE.

## Operation
- States:
  - IDLE to EXEC on an accepted request.
  - EXEC to RESP unconditionally.
  - RESP to IDLE when `RSPx_READY` is high for the owning port.
- Grant, evaluated in IDLE only:
  - Only one VALID high: that requester wins.
  - Both VALID high: the requester not in `LAST` wins.
  - `LAST` is a 1-bit register, updated to the winner on acceptance. Reset value is 1, so port 0 wins the first tie.
- `REQx_READY` = (state == IDLE) && (winner == x). READY depends combinationally on VALID; requesters must not make VALID depend on READY.
- At most one READY is high in any cycle. Outside IDLE both READYs are 0.
- On accept:
  - `ALU_S`/`ALU_A`/`ALU_B` load the winner's S/A/B.
  - `OWNER` register records the winning port.
- ALU drive while not in EXEC:
  - On entering RESP, `ALU_S` is set to 0. 0 is an unused opcode, so the ALU outputs Q=0, CMP=0.
  - `ALU_A`/`ALU_B` hold their last values.
- On EXEC to RESP, `RSP_Q` and `RSP_CMP` capture `ALU_Q`/`ALU_CMP`.
- `RSPx_VALID` = (state == RESP) && (OWNER == x).
- `RSP_Q`/`RSP_CMP` hold stable until the next capture. Their value after consumption is don't-care but must not change until the next EXEC.
- No width conversion: operands pass unmodified; shift amounts and signedness are the ALU's concern.
- Reset values: all VALID/READY outputs 0; `BUSY` 0; `ALU_S`/`ALU_A`/`ALU_B` 0; `RSP_Q` 0; `RSP_CMP` 0; `LAST` 1; `OWNER` 0; state IDLE.

## Timing
- Request accepted at edge E0: EXEC is the cycle after E0; the result is captured at E1; `RSPx_VALID` is high from E1.
- Minimum latency is 2 edges from accept to response valid.
- Response consumed at edge En: IDLE after En; a new accept is possible at En+1. Minimum initiation interval is 3 cycles.
- Response backpressure is unbounded; state stays RESP and outputs are held.
- The non-owner's VALID is ignored (READY 0) until IDLE. With both VALID held continuously, grants alternate 0,1,0,1.
- `RST` during EXEC or RESP returns to IDLE at that edge. The in-flight result is discarded and no response is issued.
- `RST` has priority over every other event on the same edge.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined:
  - Port 0 always wins ties.
  - `LAST` is not implemented; port 1 is granted only when `REQ0_VALID` is 0.
- `ALU_ARB_FIXED_PRIO_EN` undefined: round-robin as described in Operation.

## Test plan
- ADD: REQ0 S=6'b000001, A=5, B=7 → `RSP0_VALID` 2 edges after accept; `RSP_Q`=12; `RSP_CMP`=0; `RSP1_VALID` stays 0.
- Tie after reset: both VALID high (REQ0 SUB 10-3, REQ1 SLTU 1<2), both held, RSP_READY tied high:
  - Default build: port 0 is served first with Q=7, then port 1 with Q=1.
  - `ALU_ARB_FIXED_PRIO_EN` build: port 0 is served repeatedly while `REQ0_VALID` stays high; port 1 is served only after REQ0 drops.
- Compare op: REQ1 S=6'b010010 (LT), A=-1, B=0 → `RSP_CMP`=1 and `RSP_Q`=0 on port 1.
- Backpressure: hold `RSP0_READY`=0 for 10 cycles → `RSP0_VALID` and `RSP_Q` stay stable; both READYs stay 0; `BUSY`=1. Raising READY returns the state to IDLE on the next edge.
- Reset mid-operation: assert `RST` in the EXEC cycle → after that edge all outputs equal their reset values and no `RSPx_VALID` pulse occurs.
- Idle drive: with no VALID high for 5 cycles after a response → `ALU_S`=0, both READYs 0, `BUSY`=0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-drive bundle around alu_arbiter.
// slave is the arbiter side; master is the requesters-plus-ALU side.
`timescale 1ns/1ps
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 6
);
    logic             req0_valid;
    logic             req1_valid;
    logic             req0_ready;
    logic             req1_ready;
    logic [OPW-1:0]   req0_s;
    logic [OPW-1:0]   req1_s;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             rsp0_valid;
    logic             rsp1_valid;
    logic             rsp0_ready;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp_q;
    logic             rsp_cmp;
    logic [OPW-1:0]   alu_s;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_q;
    logic             alu_cmp;
    logic             busy;

    modport slave (
        input  req0_valid, req1_valid, req0_s, req1_s,
               req0_a, req0_b, req1_a, req1_b,
               rsp0_ready, rsp1_ready, alu_q, alu_cmp,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
               rsp_q, rsp_cmp, alu_s, alu_a, alu_b, busy
    );

    modport master (
        output req0_valid, req1_valid, req0_s, req1_s,
               req0_a, req0_b, req1_a, req1_b,
               rsp0_ready, rsp1_ready, alu_q, alu_cmp,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
               rsp_q, rsp_cmp, alu_s, alu_a, alu_b, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter sharing one combinational ALU; registers operands, holds result.
// Define ALU_ARB_FIXED_PRIO_EN to give port 0 fixed priority instead of round-robin.
`timescale 1ns/1ps
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 6
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             owner;
    logic             win1;
    logic             accept;
    logic             rsp_take;
    logic [OPW-1:0]   alu_s_r;
    logic [WIDTH-1:0] alu_a_r;
    logic [WIDTH-1:0] alu_b_r;
    logic [WIDTH-1:0] rsp_q_r;
    logic             rsp_cmp_r;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign win1 = bus.req1_valid && !bus.req0_valid;
`else
    logic last;

    // On a tie the port that was not served most recently wins.
    assign win1 = bus.req1_valid && (!bus.req0_valid || !last);

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= win1;
        end
    end
`endif

    assign accept   = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
    assign rsp_take = owner ? bus.rsp1_ready : bus.rsp0_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: each always_comb assigns a default first so no path leaves a latch behind.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_take) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        bus.busy       = (state != IDLE);
        if (state == IDLE) begin
            bus.req0_ready = bus.req0_valid && !win1;
            bus.req1_ready = win1;
        end
        if (state == RESP) begin
            bus.rsp0_valid = !owner;
            bus.rsp1_valid = owner;
        end
    end

    // Opcode drops to 0 once the result is captured so the ALU idles at Q=0, CMP=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= 1'b0;
            alu_s_r   <= '0;
            alu_a_r   <= '0;
            alu_b_r   <= '0;
            rsp_q_r   <= '0;
            rsp_cmp_r <= 1'b0;
        end else begin
            if (accept) begin
                owner   <= win1;
                alu_s_r <= win1 ? bus.req1_s : bus.req0_s;
                alu_a_r <= win1 ? bus.req1_a : bus.req0_a;
                alu_b_r <= win1 ? bus.req1_b : bus.req0_b;
            end
            if (state == EXEC) begin
                alu_s_r   <= '0;
                rsp_q_r   <= bus.alu_q;
                rsp_cmp_r <= bus.alu_cmp;
            end
        end
    end

    assign bus.alu_s   = alu_s_r;
    assign bus.alu_a   = alu_a_r;
    assign bus.alu_b   = alu_b_r;
    assign bus.rsp_q   = rsp_q_r;
    assign bus.rsp_cmp = rsp_cmp_r;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run
// against a transaction-level model; the bench also plays the role of the ALU.
`timescale 1ns/1ps
module tb_alu_arbiter;
    localparam int WIDTH = 32;
    localparam int OPW   = 6;
    localparam logic [OPW-1:0] OP_ADD  = 6'b000001;
    localparam logic [OPW-1:0] OP_SUB  = 6'b000010;
    localparam logic [OPW-1:0] OP_SLTU = 6'b000011;
    localparam logic [OPW-1:0] OP_LT   = 6'b010010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    alu_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] alu_q_fn(input logic [OPW-1:0] s,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (s)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLTU: return {{(WIDTH-1){1'b0}}, (a < b)};
            OP_LT:   return '0;
            6'd0:    return '0;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic alu_cmp_fn(input logic [OPW-1:0] s,
                                        input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b);
        if (s == OP_LT) return $signed(a) < $signed(b);
        return 1'b0;
    endfunction

    assign bus.alu_q   = alu_q_fn(bus.alu_s, bus.alu_a, bus.alu_b);
    assign bus.alu_cmp = alu_cmp_fn(bus.alu_s, bus.alu_a, bus.alu_b);

    function automatic logic [OPW-1:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return OP_ADD;
            1:       return OP_SUB;
            2:       return OP_SLTU;
            3:       return OP_LT;
            4:       return '0;
            default: return OPW'($urandom_range(4, 63));
        endcase
    endfunction

    task automatic clear_inputs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_s     = '0;
        bus.req1_s     = '0;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req1_a     = '0;
        bus.req1_b     = '0;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Polls just after each falling edge for a grant; port is -1 if none within budget.
    task automatic wait_grant(input int budget, output int port, output int waited);
        bit done;
        done   = 1'b0;
        port   = -1;
        waited = 0;
        for (int i = 0; i <= budget && !done; i++) begin
            #1;
            if (bus.req0_ready || bus.req1_ready) begin
                port = bus.req1_ready ? 1 : 0;
                done = 1'b1;
            end else begin
                @(negedge clk);
                waited++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.busy, bus.rsp_cmp} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b expected 000000", {bus.req0_ready, bus.req1_ready,
                     bus.rsp0_valid, bus.rsp1_valid, bus.busy, bus.rsp_cmp});
        end
        vectors++;
        if ({bus.alu_s, bus.alu_a, bus.alu_b, bus.rsp_q} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got s=%h a=%h b=%h q=%h expected all 0",
                     bus.alu_s, bus.alu_a, bus.alu_b, bus.rsp_q);
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        int port, waited;
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req0_s     = OP_ADD;
        bus.req0_a     = 5;
        bus.req0_b     = 7;
        wait_grant(5, port, waited);
        vectors++;
        if (port !== 0 || bus.req1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL add_grant: got port %0d ready1 %b expected port 0 ready1 0", port, bus.req1_ready);
            if (port < 0) return;
        end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        #1;
        vectors++;
        if ({bus.busy, bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready, bus.req1_ready} !== 5'b10000
            || {bus.alu_s, bus.alu_a, bus.alu_b} !== {OP_ADD, 32'd5, 32'd7}) begin
            miscompares++;
            $display("FAIL add_exec: got ctl %b s=%h a=%0d b=%0d expected ctl 10000 s=01 a=5 b=7",
                     {bus.busy, bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready, bus.req1_ready},
                     bus.alu_s, bus.alu_a, bus.alu_b);
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp_cmp} !== 3'b100 || bus.rsp_q !== 32'd12
            || bus.alu_s !== '0) begin
            miscompares++;
            $display("FAIL add_resp: got v0v1cmp %b q=%0d alu_s=%h expected 100 q=12 alu_s=0",
                     {bus.rsp0_valid, bus.rsp1_valid, bus.rsp_cmp}, bus.rsp_q, bus.alu_s);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.rsp0_valid !== 1'b0 || bus.rsp_q !== 32'd12) begin
            miscompares++;
            $display("FAIL add_done: got busy %b v0 %b q=%0d expected busy 0 v0 0 q=12",
                     bus.busy, bus.rsp0_valid, bus.rsp_q);
        end
    endtask

    task automatic test_tie();
        int port, waited, exp_port;
        logic [WIDTH-1:0] exp_q;
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_s     = OP_SUB;
        bus.req0_a     = 10;
        bus.req0_b     = 3;
        bus.req1_valid = 1'b1;
        bus.req1_s     = OP_SLTU;
        bus.req1_a     = 1;
        bus.req1_b     = 2;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
`ifdef ALU_ARB_FIXED_PRIO_EN
            if (i == 3) bus.req0_valid = 1'b0;
            exp_port = (i == 3) ? 1 : 0;
`else
            exp_port = i % 2;
`endif
            exp_q = (exp_port == 0) ? 32'd7 : 32'd1;
            wait_grant(5, port, waited);
            vectors++;
            if (port !== exp_port || waited !== 0 || (bus.req0_ready && bus.req1_ready)) begin
                miscompares++;
                $display("FAIL tie_grant%0d: got port %0d after %0d idle cycles expected port %0d after 0",
                         i, port, waited, exp_port);
                if (port < 0) return;
            end
            repeat (2) @(negedge clk);
            #1;
            vectors++;
            if ({bus.rsp0_valid, bus.rsp1_valid} !== ((port == 1) ? 2'b01 : 2'b10) || bus.rsp_q !== exp_q) begin
                miscompares++;
                $display("FAIL tie_resp%0d: got v0v1 %b q=%0d expected port %0d q=%0d",
                         i, {bus.rsp0_valid, bus.rsp1_valid}, bus.rsp_q, port, exp_q);
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_compare();
        int port, waited;
        @(negedge clk);
        bus.req1_valid = 1'b1;
        bus.req1_s     = OP_LT;
        bus.req1_a     = '1;
        bus.req1_b     = '0;
        wait_grant(5, port, waited);
        vectors++;
        if (port !== 1) begin
            miscompares++;
            $display("FAIL cmp_grant: got port %0d expected 1", port);
            if (port < 0) return;
        end
        @(negedge clk);
        bus.req1_valid = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp_cmp} !== 3'b011 || bus.rsp_q !== '0) begin
            miscompares++;
            $display("FAIL cmp_resp: got v0v1cmp %b q=%h expected 011 q=0",
                     {bus.rsp0_valid, bus.rsp1_valid, bus.rsp_cmp}, bus.rsp_q);
        end
    endtask

    task automatic test_backpressure();
        int port, waited;
        @(negedge clk);
        bus.rsp0_ready = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_s     = OP_ADD;
        bus.req0_a     = 100;
        bus.req0_b     = 23;
        wait_grant(5, port, waited);
        vectors++;
        if (port !== 0) begin
            miscompares++;
            $display("FAIL bp_grant: got port %0d expected 0", port);
            if (port < 0) return;
        end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1;
        bus.req1_s     = OP_ADD;
        bus.req1_a     = 1;
        bus.req1_b     = 1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            #1;
            vectors++;
            if ({bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready, bus.req1_ready, bus.busy} !== 5'b10001
                || bus.rsp_q !== 32'd123) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got v0v1r0r1busy %b q=%0d expected 10001 q=123", i,
                         {bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready, bus.req1_ready, bus.busy}, bus.rsp_q);
            end
            @(negedge clk);
        end
        bus.rsp0_ready = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if ({bus.busy, bus.rsp0_valid, bus.req0_ready, bus.req1_ready} !== 4'b0001 || bus.rsp_q !== 32'd123) begin
            miscompares++;
            $display("FAIL bp_release: got busy v0 r0 r1 %b q=%0d expected 0001 q=123",
                     {bus.busy, bus.rsp0_valid, bus.req0_ready, bus.req1_ready}, bus.rsp_q);
        end
        bus.req1_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int port, waited;
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req0_s     = OP_SUB;
        bus.req0_a     = 50;
        bus.req0_b     = 8;
        wait_grant(5, port, waited);
        vectors++;
        if (port !== 0) begin
            miscompares++;
            $display("FAIL rstmid_grant: got port %0d expected 0", port);
            if (port < 0) return;
        end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        rst            = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.busy, bus.rsp_cmp} !== 6'b0
            || {bus.alu_s, bus.alu_a, bus.alu_b, bus.rsp_q} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_state: got ctl %b s=%h a=%h b=%h q=%h expected all 0",
                     {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.busy, bus.rsp_cmp},
                     bus.alu_s, bus.alu_a, bus.alu_b, bus.rsp_q);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            vectors++;
            if ({bus.rsp0_valid, bus.rsp1_valid, bus.busy} !== 3'b000) begin
                miscompares++;
                $display("FAIL rstmid_quiet%0d: got v0v1busy %b expected 000", i,
                         {bus.rsp0_valid, bus.rsp1_valid, bus.busy});
            end
        end
    endtask

    task automatic test_idle_drive();
        int port, waited;
        @(negedge clk);
        bus.req1_valid = 1'b1;
        bus.req1_s     = OP_ADD;
        bus.req1_a     = 2;
        bus.req1_b     = 3;
        wait_grant(5, port, waited);
        vectors++;
        if (port !== 1) begin
            miscompares++;
            $display("FAIL idle_grant: got port %0d expected 1", port);
            if (port < 0) return;
        end
        @(negedge clk);
        bus.req1_valid = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (bus.rsp1_valid !== 1'b1 || bus.rsp_q !== 32'd5) begin
            miscompares++;
            $display("FAIL idle_resp: got v1 %b q=%0d expected v1 1 q=5", bus.rsp1_valid, bus.rsp_q);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            vectors++;
            if ({bus.req0_ready, bus.req1_ready, bus.busy} !== 3'b000 || bus.alu_s !== '0
                || bus.alu_a !== 32'd2 || bus.alu_b !== 32'd3) begin
                miscompares++;
                $display("FAIL idle_drive%0d: got r0r1busy %b s=%h a=%0d b=%0d expected 000 s=0 a=2 b=3", i,
                         {bus.req0_ready, bus.req1_ready, bus.busy}, bus.alu_s, bus.alu_a, bus.alu_b);
            end
        end
    endtask

    // Transaction model: one operation in flight, result two edges after grant, held until taken.
    task automatic test_random();
        int               phase;
        int               owner;
        int               w;
        bit               pv [2];
        logic [OPW-1:0]   ps [2];
        logic [WIDTH-1:0] pa [2];
        logic [WIDTH-1:0] pb [2];
        logic [OPW-1:0]   ms;
        logic [WIDTH-1:0] ma, mb, mq;
        logic             mcmp, rr0, rr1;
        logic [5:0]       exp_ctl, got_ctl;
`ifndef ALU_ARB_FIXED_PRIO_EN
        int               last;
        last = 1;
`endif
        do_reset();
        phase = 0;
        owner = 0;
        ms = '0; ma = '0; mb = '0; mq = '0; mcmp = 1'b0;
        for (int k = 0; k < 2; k++) begin
            pv[k] = 1'b0; ps[k] = '0; pa[k] = '0; pb[k] = '0;
        end
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!pv[k] && $urandom_range(0, 2) == 0) begin
                    pv[k] = 1'b1;
                    ps[k] = rand_op();
                    pa[k] = $urandom;
                    pb[k] = $urandom;
                end
            end
            rr0 = 1'($urandom_range(0, 1));
            rr1 = 1'($urandom_range(0, 1));
            bus.req0_valid = pv[0]; bus.req0_s = ps[0]; bus.req0_a = pa[0]; bus.req0_b = pb[0];
            bus.req1_valid = pv[1]; bus.req1_s = ps[1]; bus.req1_a = pa[1]; bus.req1_b = pb[1];
            bus.rsp0_ready = rr0;
            bus.rsp1_ready = rr1;
            #1;
            w = -1;
            if (phase == 0) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                if (pv[0]) w = 0;
                else if (pv[1]) w = 1;
`else
                if (pv[0] && pv[1]) w = (last == 1) ? 0 : 1;
                else if (pv[0]) w = 0;
                else if (pv[1]) w = 1;
`endif
            end
            exp_ctl = {w == 0, w == 1, phase != 0, phase == 2 && owner == 0, phase == 2 && owner == 1, mcmp};
            got_ctl = {bus.req0_ready, bus.req1_ready, bus.busy, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_cmp};
            vectors++;
            if (got_ctl !== exp_ctl) begin
                miscompares++;
                $display("FAIL rand_ctl@%0d: got r0 r1 busy v0 v1 cmp %b expected %b", c, got_ctl, exp_ctl);
            end
            vectors++;
            if (bus.rsp_q !== mq) begin
                miscompares++;
                $display("FAIL rand_q@%0d: got %h expected %h", c, bus.rsp_q, mq);
            end
            vectors++;
            if ({bus.alu_s, bus.alu_a, bus.alu_b} !== {ms, ma, mb}) begin
                miscompares++;
                $display("FAIL rand_alu@%0d: got s=%h a=%h b=%h expected s=%h a=%h b=%h",
                         c, bus.alu_s, bus.alu_a, bus.alu_b, ms, ma, mb);
            end
            case (phase)
                0: if (w >= 0) begin
                    phase = 1;
                    owner = w;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    last  = w;
`endif
                    ms    = ps[w];
                    ma    = pa[w];
                    mb    = pb[w];
                    pv[w] = 1'b0;
                end
                1: begin
                    phase = 2;
                    mq    = alu_q_fn(ms, ma, mb);
                    mcmp  = alu_cmp_fn(ms, ma, mb);
                    ms    = '0;
                end
                default: if ((owner == 1) ? rr1 : rr0) phase = 0;
            endcase
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_add();
        test_tie();
        test_compare();
        test_backpressure();
        test_reset_mid();
        test_idle_drive();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 ns");
        $fatal(1, "timeout");
    end
endmodule
